wait_queue: RTL
===============

WAIT_QUEUE -- requirements
Module: wait_queue

Interface
REQ-001 SHALL have parameter DEPTH, default 4: queue entries; power of two, at least 2.
REQ-002 SHALL have parameter DATA_W, default 69: width of the opaque decoded-instruction payload.
REQ-003 SHALL have parameter RW, default 6: register index width; NREG = 2**RW ({fpr,gpr}).
REQ-004 SHALL have port clk, input, 1: single clock, rising edge.
REQ-005 SHALL have port rst, input, 1: asynchronous reset, active-high.
REQ-006 SHALL have port in_vld, input, 2: per-slot valid; slot 0 is older.
REQ-007 SHALL have ports in_data, input, 2*DATA_W, and in_ds/in_dt/in_dd, input, 2*RW each: payload and source/source/destination indices; slot k occupies bits [k*W +: W].
REQ-008 SHALL have port in_rdy, output, 1: asserted when at least 2 entries are free.
REQ-009 SHALL have ports out_vld, output, 2, and out_rdy, input, 2: issue handshake; slot 0 is the head entry, slot 1 is head+1.
REQ-010 SHALL have port out_data, output, 2*DATA_W: payloads of the head and head+1 entries.
REQ-011 SHALL have ports wb_vld, input, 2, and wb_reg, input, 2*RW: writeback busy-clear requests.
REQ-012 SHALL have port flush, input, 1: discards all queued entries.
REQ-013 SHALL have port board, output, NREG: registered busy bit per register.
REQ-014 SHALL have port count, output, $clog2(DEPTH+1): number of occupied entries.

Function
REQ-015 SHALL store entries in a circular buffer; head and tail pointers wrap modulo DEPTH.
REQ-016 SHALL treat register indices 0 and NREG/2 as zero registers: never set busy, never a hazard source.
REQ-017 SHALL enqueue on in_rdy & |in_vld, taking valid slots in order 0 then 1; in_vld=2'b10 enqueues slot 1 alone as one entry.
REQ-018 SHALL compute in_rdy from registered count only, so in_rdy = (DEPTH - count >= 2), regardless of same-cycle issue.
REQ-019 SHALL give an entry ready = no busy bit in board at its ds, dt or dd (RAW and WAW).
REQ-020 SHALL drive out_vld[0] = (count>=1) & head ready, combinationally from registered state.
REQ-021 SHALL drive out_vld[1] = out_vld[0] & (count>=2) & head+1 ready & (head+1 ds/dt/dd differ from head dd, unless head dd is a zero register).
REQ-022 SHALL issue slot 0 on out_vld[0]&out_rdy[0]; SHALL issue slot 1 only on out_vld[1]&out_rdy[1] in the same cycle that slot 0 issues (in-order issue, no bypass).
REQ-023 SHALL set board[dd] at the clock edge of each issued entry's issue.
REQ-024 SHALL clear board[wb_reg k] at the edge on wb_vld[k].
REQ-025 SHALL resolve a set and a clear of the same register in one cycle as set; clearing a non-busy register SHALL have no effect.
REQ-026 SHALL make writeback clears visible to the ready check from the next cycle: latency enqueue->eligible 1 cycle, wb->dependent issue 1 cycle.
REQ-027 SHALL allow enqueue and issue in the same cycle: count_next = count + enq - iss.
REQ-028 On flush, SHALL empty the queue at the edge (count=0, head=tail), SHALL ignore same-cycle enqueue and issue, and SHALL keep board plus same-cycle wb clears.
REQ-029 SHALL keep out_data of slots with out_vld=0 don't-care, with payload registers unchanged.

Reset
REQ-030 While rst=1, SHALL hold head=tail=0, count=0, board=0, out_vld=0 and in_rdy=1, asynchronously and independent of clk.
REQ-031 SHALL discard entries in flight when rst asserts mid-operation; the first enqueue after deassertion SHALL land at entry 0.

Verification
REQ-032 Reset then enqueue in_vld=11 with dd0=3, dd1=5, out_rdy=11 -> both issue the next cycle; board[3]=board[5]=1; count 2->0.
REQ-033 Head dd=3 and head+1 ds=3, out_rdy=11 -> only slot 0 issues; next cycle the head (ds=3) has out_vld[0]=0 until wb_vld[0], wb_reg=3; it issues the cycle after the wb.
REQ-034 DEPTH=4, enqueue 11 twice with out_rdy=00 -> count=4, in_rdy=0; third enqueue ignored; later issues wrap pointers, payload order preserved.
REQ-035 in_vld=10 with payload 0x1AB in slot 1 -> one entry, count=1, out_data slot 0 = 0x1AB.
REQ-036 Issue with dd=0 and dd=32 -> board stays 0; dependents on r0/r32 issue back-to-back.
REQ-037 flush with count=3, board[7]=1 and same-cycle wb_reg=7 -> count=0, board[7]=0; assert rst mid-stream -> all outputs at reset values immediately.

Source files
------------

// File: rtl/wait_queue.sv
// In-order dual-issue wait queue with a register busy board (scoreboard).
// Holds decoded instructions until their source/destination registers are free.
module wait_queue #(
  parameter int DEPTH  = 4,
  parameter int DATA_W = 69,
  parameter int RW     = 6
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [1:0]                 in_vld,
  input  logic [2*DATA_W-1:0]        in_data,
  input  logic [2*RW-1:0]            in_ds,
  input  logic [2*RW-1:0]            in_dt,
  input  logic [2*RW-1:0]            in_dd,
  output logic                       in_rdy,
  output logic [1:0]                 out_vld,
  input  logic [1:0]                 out_rdy,
  output logic [2*DATA_W-1:0]        out_data,
  input  logic [1:0]                 wb_vld,
  input  logic [2*RW-1:0]            wb_reg,
  input  logic                       flush,
  output logic [2**RW-1:0]           board,
  output logic [$clog2(DEPTH+1)-1:0] count
);
  localparam int NREG = 2**RW;
  localparam int PW   = $clog2(DEPTH);
  localparam int CW   = $clog2(DEPTH+1);

  logic [DATA_W-1:0] data_mem [DEPTH];
  logic [RW-1:0]     ds_mem   [DEPTH];
  logic [RW-1:0]     dt_mem   [DEPTH];
  logic [RW-1:0]     dd_mem   [DEPTH];

  logic [PW-1:0]   head_reg, head_next, tail_reg, tail_next;
  logic [CW-1:0]   count_reg, count_next;
  logic [NREG-1:0] board_reg, board_next;

  logic [PW-1:0] slot_idx [2];
  logic [RW-1:0] slot_ds  [2];
  logic [RW-1:0] slot_dt  [2];
  logic [RW-1:0] slot_dd  [2];
  logic [1:0]    ent_rdy;
  logic          hd_clash;
  logic [1:0]    iss;
  logic [1:0]    wr_en;
  logic [PW-1:0] wr_idx [2];
  logic          enq;
  logic [1:0]    enq_n, iss_n;

  assign slot_idx[0] = head_reg;
  assign slot_idx[1] = head_reg + PW'(1);

  // Zero registers are never set in the board, so reading their bit is always 0.
  for (genvar gi = 0; gi < 2; gi++) begin : g_slot
    assign slot_ds[gi]  = ds_mem[slot_idx[gi]];
    assign slot_dt[gi]  = dt_mem[slot_idx[gi]];
    assign slot_dd[gi]  = dd_mem[slot_idx[gi]];
    assign ent_rdy[gi]  = ~(board_reg[slot_ds[gi]] | board_reg[slot_dt[gi]] |
                            board_reg[slot_dd[gi]]);
    assign out_data[gi*DATA_W +: DATA_W] = data_mem[slot_idx[gi]];
  end

  // head+1 may not touch the register the head is about to claim.
  assign hd_clash = (slot_dd[0][RW-2:0] != '0) &&
                    ((slot_ds[1] == slot_dd[0]) || (slot_dt[1] == slot_dd[0]) ||
                     (slot_dd[1] == slot_dd[0]));

  assign out_vld[0] = (count_reg != '0) & ent_rdy[0];
  assign out_vld[1] = out_vld[0] & (count_reg >= CW'(2)) & ent_rdy[1] & ~hd_clash;
  assign in_rdy     = (count_reg <= CW'(DEPTH-2));

  assign iss[0] = out_vld[0] & out_rdy[0] & ~flush;
  assign iss[1] = iss[0] & out_vld[1] & out_rdy[1];
  assign enq    = in_rdy & (|in_vld) & ~flush;

  // A lone slot-1 request takes the tail entry itself.
  assign wr_en[0]  = enq & in_vld[0];
  assign wr_en[1]  = enq & in_vld[1];
  assign wr_idx[0] = tail_reg;
  assign wr_idx[1] = in_vld[0] ? tail_reg + PW'(1) : tail_reg;

  assign enq_n = {1'b0, wr_en[0]} + {1'b0, wr_en[1]};
  assign iss_n = {1'b0, iss[0]} + {1'b0, iss[1]};

  always_ff @(posedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (wr_en[k]) begin
        data_mem[wr_idx[k]] <= in_data[k*DATA_W +: DATA_W];
        ds_mem[wr_idx[k]]   <= in_ds[k*RW +: RW];
        dt_mem[wr_idx[k]]   <= in_dt[k*RW +: RW];
        dd_mem[wr_idx[k]]   <= in_dd[k*RW +: RW];
      end
    end
  end

  always_comb begin
    head_next  = head_reg;
    tail_next  = tail_reg;
    count_next = count_reg;
    if (flush) begin
      head_next  = tail_reg;
      count_next = '0;
    end else begin
      head_next  = head_reg + PW'(iss_n);
      tail_next  = tail_reg + PW'(enq_n);
      count_next = count_reg + CW'(enq_n) - CW'(iss_n);
    end
  end

  // Set beats clear on the same register; zero registers never become busy.
  for (genvar gi = 0; gi < NREG; gi++) begin : g_board
    localparam bit ZERO = ((gi % (NREG/2)) == 0);
    logic set_bit, clr_bit;
    assign set_bit = !ZERO && ((iss[0] && slot_dd[0] == RW'(gi)) ||
                               (iss[1] && slot_dd[1] == RW'(gi)));
    assign clr_bit = (wb_vld[0] && wb_reg[RW-1:0] == RW'(gi)) ||
                     (wb_vld[1] && wb_reg[2*RW-1:RW] == RW'(gi));
    assign board_next[gi] = set_bit | (board_reg[gi] & ~clr_bit);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head_reg  <= '0;
      tail_reg  <= '0;
      count_reg <= '0;
      board_reg <= '0;
    end else begin
      head_reg  <= head_next;
      tail_reg  <= tail_next;
      count_reg <= count_next;
      board_reg <= board_next;
    end
  end

  assign board = board_reg;
  assign count = count_reg;
endmodule
